// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fixed-priority (data over fetch) arbiter for one shared variable-latency memory.
// Optional fetch anti-starvation arbitration enabled by defining ARB_FAIR_EN.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = 255,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, DM_ACC, IF_ACC, RESP} state_t;

    state_t     state, state_next;
    logic       grant_dm, grant_if, force_if, acc_done, timed_out;
    logic [7:0] tmo_cnt;

`ifdef ARB_FAIR_EN
    logic [2:0] starve_cnt;

    // Once data has won STARVE_LIMIT times over a waiting fetch, fetch takes the next slot.
    assign force_if = if_req && (starve_cnt >= 3'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_dm && if_req && (starve_cnt < 3'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_dm   = 1'b0;
        grant_if   = 1'b0;
        acc_done   = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (dm_req && !force_if) begin
                    grant_dm   = 1'b1;
                    state_next = DM_ACC;
                end else if (if_req) begin
                    grant_if   = 1'b1;
                    state_next = IF_ACC;
                end
            end
            DM_ACC, IF_ACC: begin
                if (mem_ready) begin
                    acc_done   = 1'b1;
                    state_next = RESP;
                end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
                    timed_out  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_ack    <= 1'b0;
            dm_rdata  <= '0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            tmo_cnt   <= '0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            err    <= 1'b0;
            if (grant_dm || grant_if) begin
                mem_req  <= 1'b1;
                mem_we   <= grant_dm && dm_we;
                mem_addr <= grant_dm ? dm_addr : if_addr;
                if (grant_dm) begin
                    mem_wdata <= dm_wdata;
                end
                tmo_cnt <= '0;
            end
            if (acc_done || timed_out) begin
                mem_req <= 1'b0;
                err     <= timed_out;
                if (state == DM_ACC) begin
                    dm_ack   <= 1'b1;
                    dm_rdata <= timed_out ? '0 : mem_rdata;
                end else begin
                    if_ack   <= 1'b1;
                    if_rdata <= timed_out ? '0 : mem_rdata;
                end
            end else if (state == DM_ACC || state == IF_ACC) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with an ack scoreboard.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    typedef struct {
        logic        is_dm;
        logic        chk_rd;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Every ack pops the oldest expected response and compares side, err and read data.
    always @(negedge clk) begin
        if (if_ack || dm_ack) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_ack: if_ack=%0b dm_ack=%0b, required no ack", if_ack, dm_ack);
            end else begin
                mon_e = sb.pop_front();
                if (dm_ack !== mon_e.is_dm || if_ack !== !mon_e.is_dm) begin
                    $display("FAIL ack_side: if_ack=%0b dm_ack=%0b, required dm_ack=%0b", if_ack, dm_ack, mon_e.is_dm);
                end else begin
                    n_pass++;
                end
                n_checks++;
                if (err !== mon_e.err) begin
                    $display("FAIL ack_err: err=%0b, required %0b", err, mon_e.err);
                end else begin
                    n_pass++;
                end
                if (mon_e.chk_rd) begin
                    n_checks++;
                    if ((mon_e.is_dm ? dm_rdata : if_rdata) !== mon_e.rdata) begin
                        $display("FAIL ack_rdata: rdata=%h, required %h", mon_e.is_dm ? dm_rdata : if_rdata, mon_e.rdata);
                    end else begin
                        n_pass++;
                    end
                end
            end
        end
    end

    task automatic mem_respond(input int wait_n, input logic [31:0] d);
        int t = 0;
        while (!mem_req && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (!mem_req) begin
            n_checks++;
            $display("FAIL mem_req_wait: mem_req=%0b after %0d cycles, required 1", mem_req, t);
            return;
        end
        repeat (wait_n) @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = d;
        @(negedge clk);
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({if_ack, dm_ack, err, mem_req, mem_we, if_rdata, dm_rdata, mem_addr, mem_wdata} !== '0) begin
            $display("FAIL reset_outputs: mem_req=%0b mem_addr=%h if_rdata=%h dm_rdata=%h, required all 0",
                     mem_req, mem_addr, if_rdata, dm_rdata);
        end else begin
            n_pass++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h3000; dm_wdata = 32'h11;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
            $display("FAIL rst_mid_grant: mem_req=%0b mem_we=%0b, required 1 1", mem_req, mem_we);
        end else begin
            n_pass++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
            $display("FAIL rst_mid_async: mem_req=%0b mem_we=%0b, required 0 0", mem_req, mem_we);
        end else begin
            n_pass++;
        end
        dm_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0 || dm_ack !== 1'b0) begin
            $display("FAIL rst_mid_after: mem_req=%0b dm_ack=%0b, required 0 0", mem_req, dm_ack);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_fetch_zero_wait();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_0010;
        sb.push_back('{is_dm: 1'b0, chk_rd: 1'b1, rdata: 32'h0000_0013, err: 1'b0});
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10) begin
            $display("FAIL fetch_mem: mem_req=%0b mem_we=%0b mem_addr=%h, required 1 0 00000010", mem_req, mem_we, mem_addr);
        end else begin
            n_pass++;
        end
        mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
        @(negedge clk);
        n_checks++;
        if (if_ack !== 1'b1 || err !== 1'b0 || mem_req !== 1'b0) begin
            $display("FAIL fetch_ack_n2: if_ack=%0b err=%0b mem_req=%0b, required 1 0 0", if_ack, err, mem_req);
        end else begin
            n_pass++;
        end
        mem_ready = 1'b0; if_req = 1'b0;
    endtask

    task automatic test_priority();
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h1000; dm_wdata = 32'hDEADBEEF;
        if_req = 1'b1; if_addr = 32'h14;
        sb.push_back('{is_dm: 1'b1, chk_rd: 1'b0, rdata: 32'h0, err: 1'b0});
        sb.push_back('{is_dm: 1'b0, chk_rd: 1'b1, rdata: 32'h93, err: 1'b0});
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h1000 || mem_wdata !== 32'hDEADBEEF) begin
            $display("FAIL prio_store: mem_req=%0b mem_we=%0b mem_addr=%h mem_wdata=%h, required 1 1 00001000 deadbeef",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end else begin
            n_pass++;
        end
        mem_ready = 1'b1; mem_rdata = 32'h5555_5555;
        @(negedge clk);
        mem_ready = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0) begin
            $display("FAIL prio_idle_gap: mem_req=%0b, required 0", mem_req);
        end else begin
            n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h14) begin
            $display("FAIL prio_fetch: mem_req=%0b mem_we=%0b mem_addr=%h, required 1 0 00000014", mem_req, mem_we, mem_addr);
        end else begin
            n_pass++;
        end
        mem_ready = 1'b1; mem_rdata = 32'h93;
        @(negedge clk);
        mem_ready = 1'b0; if_req = 1'b0;
    endtask

    task automatic test_slow_load();
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
        sb.push_back('{is_dm: 1'b1, chk_rd: 1'b1, rdata: 32'hCAFEF00D, err: 1'b0});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h2000 || dm_ack !== 1'b0) begin
                $display("FAIL slow_stable_%0d: mem_req=%0b mem_we=%0b mem_addr=%h dm_ack=%0b, required 1 0 00002000 0",
                         i, mem_req, mem_we, mem_addr, dm_ack);
            end else begin
                n_pass++;
            end
        end
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_ready = 1'b0; dm_req = 1'b0;
        n_checks++;
        if (dm_ack !== 1'b1 || if_rdata !== 32'h93) begin
            $display("FAIL slow_ack: dm_ack=%0b if_rdata=%h, required 1 00000093", dm_ack, if_rdata);
        end else begin
            n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (dm_ack !== 1'b0) begin
            $display("FAIL slow_single_ack: dm_ack=%0b, required 0", dm_ack);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_timeout();
        int cnt = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h40;
        sb.push_back('{is_dm: 1'b0, chk_rd: 1'b1, rdata: 32'h0, err: 1'b1});
        @(negedge clk);
        while (mem_req && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (cnt !== 255) begin
            $display("FAIL timeout_cycles: mem_req held %0d cycles, required 255", cnt);
        end else begin
            n_pass++;
        end
        n_checks++;
        if (if_ack !== 1'b1 || err !== 1'b1 || if_rdata !== 32'h0) begin
            $display("FAIL timeout_ack: if_ack=%0b err=%0b if_rdata=%h, required 1 1 00000000", if_ack, err, if_rdata);
        end else begin
            n_pass++;
        end
        if_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic exp_dm;
        for (int i = 0; i < 6; i++) begin
`ifdef ARB_FAIR_EN
            exp_dm = (i != 4);
`else
            exp_dm = 1'b1;
`endif
            sb.push_back('{is_dm: exp_dm, chk_rd: 1'b1, rdata: 32'hA000_0000 + 32'(i), err: 1'b0});
        end
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4000;
        if_req = 1'b1; if_addr = 32'h20;
        for (int i = 0; i < 6; i++) begin
            mem_respond(0, 32'hA000_0000 + 32'(i));
        end
        dm_req = 1'b0; if_req = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            $display("FAIL b2b_pending: %0d expected acks outstanding, required 0", sb.size());
        end else begin
            n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_access();
        test_fetch_zero_wait();
        test_priority();
        test_slow_load();
        test_timeout();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
